// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin arbiter and sequencer for the shared system bus.
//             Grants one requester, drives its transaction onto the bus,
//             waits for the slave's function-complete (or a timeout), returns
//             data/status, then releases the bus for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // master side
    input  logic [NUM_MASTERS-1:0]                m_req,
    input  logic [NUM_MASTERS*ADDR_BUS_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_BUS_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]                m_wr,
    input  logic [NUM_MASTERS-1:0]                m_rd,
    output logic [NUM_MASTERS-1:0]                m_grant,
    output logic [NUM_MASTERS-1:0]                m_done,
    output logic                                  m_err,
    output logic [DATA_BUS_WIDTH-1:0]             m_rdata,
    // shared bus side
    output logic [ADDR_BUS_WIDTH-1:0]             addr_bus,
    inout  wire  [DATA_BUS_WIDTH-1:0]             data_bus,
    output logic                                  wr_bus,
    output logic                                  rd_bus,
    input  logic                                  fc_bus
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // After reset the "last granted" master is the highest index, so the
    // rotation starts at master 0.
    localparam logic [IDX_W-1:0] C_LAST_RESET = IDX_W'(NUM_MASTERS - 1);
    // Counter value seen on the final permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W:0]   C_NUM_M      = (IDX_W+1)'(NUM_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [NUM_MASTERS-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]          last_q,  last_d;    // last granted == current owner
    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic                      err_q,   err_d;
    logic [DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;

    // ------------------------------------------------------------------------
    // Unpacked views of the flattened master buses
    // ------------------------------------------------------------------------
    logic [ADDR_BUS_WIDTH-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_BUS_WIDTH-1:0] wdata_arr [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign addr_arr[gi]  = m_addr[gi*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
        assign wdata_arr[gi] = m_wdata[gi*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
    end

    // Owner's live request, used while the bus is held.
    logic                      own_rd;
    logic                      own_wr;
    logic [ADDR_BUS_WIDTH-1:0] own_addr;
    logic [DATA_BUS_WIDTH-1:0] own_wdata;

    assign own_rd    = m_rd[last_q];
    assign own_wr    = m_wr[last_q];
    assign own_addr  = addr_arr[last_q];
    assign own_wdata = wdata_arr[last_q];

    // ------------------------------------------------------------------------
    // Round-robin pick: first requester scanning last+1, last+2, ... mod N
    // ------------------------------------------------------------------------
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan candidates in rotation order and keep the first requester found.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand = (IDX_W+1)'(last_q) + (IDX_W+1)'(off);
            if (cand >= C_NUM_M) begin
                cand = cand - C_NUM_M;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!win_found && m_req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // A request is legal only when exactly one of read/write is asked for.
    logic win_legal;
    assign win_legal = m_rd[win_idx] ^ m_wr[win_idx];

    // Only a clean logic 1 on fc_bus counts as completion; x/z/0 do not.
    logic fc_done;
    assign fc_done = (fc_bus == 1'b1);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------

    // State registers; reset abandons any transaction without a completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= C_LAST_RESET;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for completion/timeout in ACCESS,
    // single-cycle RELEASE back to IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                cnt_d   = '0;
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    if (win_legal) begin
                        state_d = ST_ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        // Illegal request: report an error without ever
                        // touching the bus strobes.
                        state_d = ST_RELEASE;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fc_done) begin
                    if (own_rd) begin
                        rdata_d = data_bus;
                    end
                    err_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == C_CNT_LAST) begin
                    // No response within the window: abort, keep old rdata.
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus and master-side outputs
    // ------------------------------------------------------------------------
    logic drive_en;

    // Bus strobes follow the owner's live request only while in ACCESS;
    // completion is reported to the owner only during RELEASE.
    always_comb begin
        addr_bus = '0;
        rd_bus   = 1'b0;
        wr_bus   = 1'b0;
        drive_en = 1'b0;
        m_done   = '0;
        m_err    = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                addr_bus = own_addr;
                rd_bus   = own_rd;
                wr_bus   = own_wr;
                drive_en = own_wr;
            end
            ST_RELEASE: begin
                m_done = grant_q;
                m_err  = err_q;
            end
            default: begin
                addr_bus = '0;
            end
        endcase
    end

    assign m_grant  = grant_q;
    assign m_rdata  = rdata_q;
    assign data_bus = drive_en ? own_wdata : {DATA_BUS_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed self-checking bench for bus_arbiter with a small
//             memory slave (256 bytes mapped at 0x000-0x0FF, zero-wait reads,
//             writes completing one cycle late).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_wr, m_rd;
    logic [63:0] m_addr;
    logic [15:0] m_wdata;
    wire  [1:0]  m_grant, m_done;
    wire         m_err;
    wire  [7:0]  m_rdata;
    wire  [31:0] addr_bus;
    wire  [7:0]  data_bus;
    wire         wr_bus, rd_bus, fc_bus;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .NUM_MASTERS(2), .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_rd(m_rd),
        .m_grant(m_grant), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
        .addr_bus(addr_bus), .data_bus(data_bus), .wr_bus(wr_bus), .rd_bus(rd_bus),
        .fc_bus(fc_bus)
    );

    always #5 clk = ~clk;

    // Memory slave; unmapped addresses leave fc_bus low.
    logic [7:0] mem [256];
    logic       wr_flag;
    logic       mem_init;
    wire        mapped = (addr_bus < 32'h100);

    assign data_bus = (rd_bus && mapped) ? mem[addr_bus[7:0]] : 8'hzz;
    assign fc_bus   = (rd_bus && mapped) || wr_flag;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
            wr_flag    <= 1'b0;
        end else begin
            wr_flag <= wr_bus && mapped;
            if (wr_bus && mapped) mem[addr_bus[7:0]] <= data_bus;
        end
    end

    // Stimulus helper: raise one master's request, watch until its m_done,
    // then drop the request in the RELEASE cycle.
    task automatic run_txn(input int m, input logic [31:0] a, input logic [7:0] wd,
                           input logic w, input logic r,
                           output int strobes, output int lat, output logic [1:0] done_v,
                           output logic err_v, output logic [7:0] rd_v,
                           output logic [1:0] grant_v, output logic [7:0] wbus_v);
        @(negedge clk);
        m_addr[m*32 +: 32] = a;
        m_wdata[m*8 +: 8]  = wd;
        m_wr[m]            = w;
        m_rd[m]            = r;
        m_req[m]           = 1'b1;
        strobes = 0; lat = 0; done_v = 2'b00; err_v = 1'b0; rd_v = 8'h00;
        grant_v = 2'b00; wbus_v = 8'h00;
        for (int i = 0; i < 60 && done_v == 2'b00; i++) begin
            @(negedge clk);
            lat++;
            if (rd_bus || wr_bus) strobes++;
            if (wr_bus) wbus_v = data_bus;
            if (m_grant != 2'b00) grant_v = m_grant;
            done_v = m_done;
            err_v  = m_err;
            rd_v   = m_rdata;
        end
        m_req[m] = 1'b0;
        m_wr[m]  = 1'b0;
        m_rd[m]  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({m_grant, m_done, m_err, wr_bus, rd_bus} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b done=%b err=%b wr=%b rd=%b, expected all 0",
                     m_grant, m_done, m_err, wr_bus, rd_bus);
        end
        checks++;
        if (addr_bus !== 32'h0 || m_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got addr=%h rdata=%h, expected 0/0", addr_bus, m_rdata);
        end
    endtask

    task automatic test_read();
        int s, l; logic [1:0] d, g; logic e; logic [7:0] rv, wv;
        run_txn(0, 32'h10, 8'h00, 1'b0, 1'b1, s, l, d, e, rv, g, wv);
        checks++;
        if (d !== 2'b01 || l != 2) begin
            errors++;
            $display("FAIL read_done: got done=%b lat=%0d, expected 01 lat=2", d, l);
        end
        checks++;
        if (g !== 2'b01 || s != 1) begin
            errors++;
            $display("FAIL read_grant: got grant=%b strobes=%0d, expected 01 strobes=1", g, s);
        end
        checks++;
        if (rv !== 8'hA5 || e !== 1'b0) begin
            errors++;
            $display("FAIL read_data: got rdata=%h err=%b, expected A5 err=0", rv, e);
        end
        @(negedge clk);
        checks++;
        if (m_done !== 2'b00 || m_grant !== 2'b00) begin
            errors++;
            $display("FAIL read_after: got done=%b grant=%b, expected 00/00", m_done, m_grant);
        end
    endtask

    task automatic test_write();
        int s, l; logic [1:0] d, g; logic e; logic [7:0] rv, wv;
        run_txn(1, 32'h20, 8'h3C, 1'b1, 1'b0, s, l, d, e, rv, g, wv);
        checks++;
        if (d !== 2'b10 || l != 3 || e !== 1'b0) begin
            errors++;
            $display("FAIL write_done: got done=%b lat=%0d err=%b, expected 10 lat=3 err=0", d, l, e);
        end
        checks++;
        if (s != 2 || wv !== 8'h3C || g !== 2'b10) begin
            errors++;
            $display("FAIL write_bus: got strobes=%0d data=%h grant=%b, expected 2 3C 10", s, wv, g);
        end
        checks++;
        if (mem[8'h20] !== 8'h3C) begin
            errors++;
            $display("FAIL write_mem: got mem[20]=%h, expected 3C", mem[8'h20]);
        end
        run_txn(0, 32'h20, 8'h00, 1'b0, 1'b1, s, l, d, e, rv, g, wv);
        checks++;
        if (d !== 2'b01 || rv !== 8'h3C) begin
            errors++;
            $display("FAIL write_readback: got done=%b rdata=%h, expected 01 3C", d, rv);
        end
    endtask

    task automatic test_timeout();
        int s, l; logic [1:0] d, g; logic e; logic [7:0] rv, wv;
        run_txn(0, 32'h1000, 8'h00, 1'b0, 1'b1, s, l, d, e, rv, g, wv);
        checks++;
        if (s != 16 || l != 17) begin
            errors++;
            $display("FAIL timeout_len: got strobes=%0d lat=%0d, expected 16/17", s, l);
        end
        checks++;
        if (d !== 2'b01 || e !== 1'b1 || rv !== 8'h3C) begin
            errors++;
            $display("FAIL timeout_status: got done=%b err=%b rdata=%h, expected 01 1 3C", d, e, rv);
        end
    endtask

    task automatic test_illegal();
        int s, l; logic [1:0] d, g; logic e; logic [7:0] rv, wv;
        run_txn(1, 32'h10, 8'h00, 1'b1, 1'b1, s, l, d, e, rv, g, wv);
        checks++;
        if (d !== 2'b10 || e !== 1'b1 || l != 1) begin
            errors++;
            $display("FAIL illegal_status: got done=%b err=%b lat=%0d, expected 10 1 1", d, e, l);
        end
        checks++;
        if (s != 0 || rv !== 8'h3C) begin
            errors++;
            $display("FAIL illegal_bus: got strobes=%0d rdata=%h, expected 0 3C", s, rv);
        end
        run_txn(0, 32'h10, 8'h00, 1'b0, 1'b1, s, l, d, e, rv, g, wv);
        checks++;
        if (d !== 2'b01 || e !== 1'b0 || rv !== 8'hA5 || l != 2) begin
            errors++;
            $display("FAIL illegal_next: got done=%b err=%b rdata=%h lat=%0d, expected 01 0 A5 2",
                     d, e, rv, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] dv [8];
        logic [7:0] rdv [8];
        int         at [8];
        int         nd = 0;
        int         strobes = 0;
        apply_reset();
        checks++;
        if (m_rdata !== 8'h00) begin
            errors++;
            $display("FAIL b2b_reset_rdata: got %h, expected 00", m_rdata);
        end
        m_addr  = {32'h20, 32'h10};
        m_rd    = 2'b11;
        m_wr    = 2'b00;
        m_req   = 2'b11;
        for (int i = 0; i < 60 && nd < 8; i++) begin
            @(negedge clk);
            if (rd_bus || wr_bus) strobes++;
            if (m_done != 2'b00) begin
                dv[nd]  = m_done;
                rdv[nd] = m_rdata;
                at[nd]  = i;
                nd++;
            end
        end
        m_req = 2'b00;
        m_rd  = 2'b00;
        checks++;
        if (nd != 8 || strobes != 8) begin
            errors++;
            $display("FAIL b2b_count: got dones=%0d strobes=%0d, expected 8/8", nd, strobes);
        end
        for (int k = 0; k < nd; k++) begin
            checks++;
            if (dv[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
                rdv[k] !== ((k % 2 == 0) ? 8'hA5 : 8'h3C)) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got done=%b rdata=%h, expected %b %h", k, dv[k], rdv[k],
                         (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 8'hA5 : 8'h3C);
            end
            if (k > 0) begin
                checks++;
                if (at[k] - at[k-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 3", k, at[k] - at[k-1]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m_addr[31:0] = 32'h30;
        m_wdata[7:0] = 8'h55;
        m_wr         = 2'b01;
        m_rd         = 2'b00;
        m_req        = 2'b01;
        @(negedge clk);
        checks++;
        if (wr_bus !== 1'b1 || m_grant !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_access: got wr=%b grant=%b, expected 1 01", wr_bus, m_grant);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_bus !== 1'b0 || rd_bus !== 1'b0 || m_done !== 2'b00 || m_grant !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_abort: got wr=%b rd=%b done=%b grant=%b, expected 0 0 00 00",
                     wr_bus, rd_bus, m_done, m_grant);
        end
        rst    = 1'b0;
        m_addr = {32'h20, 32'h10};
        m_wr   = 2'b00;
        m_rd   = 2'b11;
        m_req  = 2'b11;
        @(negedge clk);
        checks++;
        if (m_grant !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_regrant: got grant=%b, expected 01", m_grant);
        end
        m_req = 2'b00;
        m_rd  = 2'b00;
        apply_reset();
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        m_req    = '0;
        m_wr     = '0;
        m_rd     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
